// File: rtl/ysyx_23060061_lsu.sv
// ysyx_23060061_lsu: single-outstanding load/store unit issuing one AXI-Lite transaction per request.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses; otherwise only size 3 is rejected.
module ysyx_23060061_lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;
  state_t state, state_n;
  logic [1:0] off, size;
  logic uns, aw_done, w_done, bad, accept, aw_hs, w_hs;
  logic [31:0] shifted, ext;
  logic [3:0] mask;
  assign req_ready  = (state == IDLE) && rst;
  assign arvalid    = state == RD_ADDR;
  assign rready     = state == RD_DATA;
  assign bready     = state == WR_RESP;
  assign resp_valid = state == RESP;
  assign awvalid    = (state == WR_REQ) && !aw_done;
  assign wvalid     = (state == WR_REQ) && !w_done;
  always_comb begin
    accept = req_valid && req_ready;
`ifdef LSU_MISALIGN_CHECK_EN
    bad = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
`else
    bad = req_size == 2'd3;
`endif
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    shifted = rdata >> {off, 3'b000};
    ext = size == 2'd0 ? {{24{~uns & shifted[7]}}, shifted[7:0]} :
          size == 2'd1 ? {{16{~uns & shifted[15]}}, shifted[15:0]} : shifted;
    mask = req_size == 2'd0 ? 4'b0001 : req_size == 2'd1 ? 4'b0011 : 4'b1111;
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = bad ? RESP : req_wen ? WR_REQ : RD_ADDR;
      RD_ADDR: if (arready) state_n = RD_DATA;
      RD_DATA: if (rvalid) state_n = RESP;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
      WR_RESP: if (bvalid) state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      {off, size, uns, aw_done, w_done} <= '0;
      araddr <= '0;
      awaddr <= '0;
      wdata <= '0;
      wstrb <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        off <= req_addr[1:0];
        size <= req_size;
        uns <= req_unsigned;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        araddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        awaddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        // lanes shifted past bit 31 / strobe 3 fall off
        wdata <= req_wdata << {req_addr[1:0], 3'b000};
        wstrb <= mask << req_addr[1:0];
        resp_rdata <= '0;
        resp_err <= bad;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (rready && rvalid) begin
        resp_rdata <= rresp == 2'b00 ? ext : '0;
        resp_err <= rresp != 2'b00;
      end
      if (bready && bvalid) begin
        resp_rdata <= '0;
        resp_err <= bresp != 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// tb_ysyx_23060061_lsu: vector table plus scoreboard against a small AXI-Lite SRAM model.
module tb_ysyx_23060061_lsu;
`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_ready, req_wen = 0, req_unsigned = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic arvalid, arready = 1, rvalid, rready, awvalid, awready = 1, wvalid, wready = 1, bvalid, bready;
  logic [3:0] wstrb;
  logic [1:0] rresp, bresp, bresp_cfg = 0;
  always #5 clk = ~clk;

  ysyx_23060061_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  // SRAM slave: one idle cycle between address/data handshake and the response
  logic [31:0] mem [64];
  logic r_pend, aw_got, w_got;
  logic [31:0] r_addr, cap_awaddr, cap_wdata;
  logic [3:0] cap_strb;
  int bus_cnt;
  always @(posedge clk) begin
    if (!rst) begin
      rvalid <= 0; bvalid <= 0; r_pend <= 0; aw_got <= 0; w_got <= 0;
      rdata <= 0; rresp <= 0; bresp <= 0; bus_cnt <= 0;
      for (int k = 0; k < 64; k++) mem[k] <= 0;
    end else begin
      bus_cnt <= bus_cnt + int'(arvalid && arready) + int'(awvalid && awready) + int'(wvalid && wready);
      if (rvalid && rready) rvalid <= 0;
      if (arvalid && arready) begin r_pend <= 1; r_addr <= araddr; end
      if (r_pend) begin rvalid <= 1; rdata <= mem[r_addr[7:2]]; rresp <= 0; r_pend <= 0; end
      if (awvalid && awready) begin aw_got <= 1; cap_awaddr <= awaddr; end
      if (wvalid && wready) begin w_got <= 1; cap_wdata <= wdata; cap_strb <= wstrb; end
      if (bvalid && bready) bvalid <= 0;
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++) if (cap_strb[b]) mem[cap_awaddr[7:2]][8*b +: 8] <= cap_wdata[8*b +: 8];
        bvalid <= 1; bresp <= bresp_cfg; aw_got <= 0; w_got <= 0;
      end
    end
  end

  typedef struct {
    logic wen; logic [31:0] addr; logic [31:0] wdata; logic [1:0] size; logic uns;
    logic [31:0] rdata; logic err; int lat; logic [3:0] strb; logic [31:0] wd;
  } vec_t;
  vec_t vecs[14];
  logic [32:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic take_resp(input string name);
    logic [32:0] got;
    got = {resp_rdata, resp_err};
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    check({name, "_sb"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) check({name, "_resp"}, 64'(got), 64'(exp_q.pop_front()));
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic run(input int i, input vec_t v);
    int n, b0;
    wait_ready();
    req_valid = 1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
    b0 = bus_cnt;
    exp_q.push_back({v.rdata, v.err});
    @(negedge clk);
    req_valid = 0;
    n = 1;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check($sformatf("v%0d_lat", i), 64'(n), 64'(v.lat));
    take_resp($sformatf("v%0d", i));
    if (v.err) check($sformatf("v%0d_nobus", i), 64'(bus_cnt), 64'(b0));
    else if (v.wen) begin
      check($sformatf("v%0d_awaddr", i), 64'(cap_awaddr), 64'({v.addr[31:2], 2'b00}));
      check($sformatf("v%0d_wstrb_wdata", i), 64'({cap_strb, cap_wdata}), 64'({v.strb, v.wd}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'h80000010, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b0, 4, 4'b1111, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h80000010, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 4, 4'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h80000013, 32'h00000085, 2'd0, 1'b0, 32'h0, 1'b0, 4, 4'b1000, 32'h85000000};
    vecs[3]  = '{1'b0, 32'h80000013, 32'h0, 2'd0, 1'b0, 32'hFFFFFF85, 1'b0, 4, 4'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h80000013, 32'h0, 2'd0, 1'b1, 32'h00000085, 1'b0, 4, 4'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h80000016, 32'h00008001, 2'd1, 1'b0, 32'h0, 1'b0, 4, 4'b1100, 32'h80010000};
    vecs[6]  = '{1'b0, 32'h80000016, 32'h0, 2'd1, 1'b0, 32'hFFFF8001, 1'b0, 4, 4'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h80000016, 32'h0, 2'd1, 1'b1, 32'h00008001, 1'b0, 4, 4'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h80000000, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0, 1'b0, 4, 4'b1111, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 32'h80000002, 32'h0, 2'd2, 1'b0, CHK ? 32'h0 : 32'h0000CAFE, CHK, CHK ? 1 : 4, 4'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h80000010, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1, 1, 4'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h80000011, 32'h0000ABCD, 2'd1, 1'b0, 32'h0, CHK, CHK ? 1 : 4, 4'b0110, 32'h00ABCD00};
    vecs[12] = '{1'b0, 32'h80000017, 32'h0, 2'd0, 1'b0, 32'hFFFFFF80, 1'b0, 4, 4'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h80000011, 32'h0, 2'd0, 1'b1, CHK ? 32'h000000BE : 32'h000000CD, 1'b0, 4, 4'b0, 32'h0};

    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err, req_ready, wstrb}), 64'd0);
    check("reset_addr", 64'({araddr, awaddr}), 64'd0);
    check("reset_data", 64'({wdata, resp_rdata}), 64'd0);
    rst = 1;
    @(negedge clk);
    check("ready_after_reset", 64'({req_ready, arvalid, awvalid, wvalid, resp_valid}), 64'b10000);

    for (int i = 0; i < 14; i++) run(i, vecs[i]);

    // write with late awready and an error response held under backpressure
    wait_ready();
    awready = 0; bresp_cfg = 2'b10;
    req_valid = 1; req_wen = 1; req_addr = 32'h80000020; req_wdata = 32'h12345678; req_size = 2; req_unsigned = 0;
    exp_q.push_back({32'h0, 1'b1});
    @(negedge clk);
    req_valid = 0;
    check("wr_both_valid", 64'({awvalid, wvalid}), 64'b11);
    @(negedge clk);
    check("w_drop_aw_hold", 64'({awvalid, wvalid}), 64'b10);
    @(negedge clk);
    check("aw_still_held", 64'({awvalid, wvalid, awaddr}), 64'({2'b10, 32'h80000020}));
    awready = 1;
    @(negedge clk);
    check("aw_dropped", 64'({awvalid, wvalid}), 64'b00);
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("err_held_%0d", k), 64'({resp_valid, resp_err, resp_rdata}), 64'({2'b11, 32'h0}));
      @(negedge clk);
    end
    bresp_cfg = 0;
    take_resp("bresp_err");
    @(negedge clk);
    check("idle_after_resp", 64'({resp_valid, req_ready}), 64'b01);

    // reset while a read is in flight
    wait_ready();
    req_valid = 1; req_wen = 0; req_addr = 32'h80000010; req_size = 2;
    @(negedge clk);
    req_valid = 0;
    check("mid_arvalid", 64'(arvalid), 64'd1);
    rst = 0;
    @(negedge clk);
    check("mid_reset_clear", 64'({arvalid, rready, awvalid, wvalid, resp_valid, req_ready}), 64'd0);
    rst = 1;
    @(negedge clk);
    check("mid_reset_ready", 64'({req_ready, arvalid}), 64'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
